// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: sequences LCD commands out of a 32-entry command ROM and
// captures the image the controller writes back.
//
// A start pulse walks the ROM from entry 0. Each entry is fetched and latched.
// The host waits for the controller to go idle, then issues the entry as a
// one-cycle cmd/cmd_valid strobe. Command 0 (write-out) ends the command phase
// and opens a collection window. Each controller write beat in that window
// lands in a 64x8 image memory and is added to a checksum. The window closes
// when the controller raises done.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   start                  one-cycle pulse; accepted only when idle or finished
//   CROM_rd, CROM_A        command ROM read strobe and address
//   CROM_Q                 command ROM data, valid the cycle after CROM_rd
//   cmd, cmd_valid         command to the LCD controller and its strobe
//   busy                   LCD controller busy
//   IRAM_valid/_A/_D       controller write beat: strobe, address, data
//   done                   controller completion flag
//   rd_addr, rd_data       combinational readback of the image memory
//   checksum, wr_count     sum of captured bytes, captured beats (saturating)
//   host_done, err         run finished (held), sticky protocol error
module lcd_cmd_host (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        CROM_rd,
    output logic [4:0]  CROM_A,
    input  logic [3:0]  CROM_Q,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        IRAM_valid,
    input  logic [5:0]  IRAM_A,
    input  logic [7:0]  IRAM_D,
    input  logic        done,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [13:0] checksum,
    output logic [6:0]  wr_count,
    output logic        host_done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StLatch, StWaitRdy, StIssue, StGuard, StCollect, StFinish
    } state_e;

    localparam logic [9:0] TimeoutMax = 10'd1023;
    localparam logic [3:0] FirstIllegal = 4'd12;

    state_e      state_q, state_d;
    logic [4:0]  crom_a_q, crom_a_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [13:0] checksum_q, checksum_d;
    logic [6:0]  wr_count_q, wr_count_d;
    logic        err_q, err_d;
    logic [9:0]  timeout_q, timeout_d;
    logic        advance;
    logic        capture;

    logic [7:0]  mem [64];

    assign capture = (state_q == StCollect) && IRAM_valid;

    always_comb begin
        state_d    = state_q;
        crom_a_d   = crom_a_q;
        cmd_d      = cmd_q;
        checksum_d = checksum_q;
        wr_count_d = wr_count_q;
        // A write beat outside the collection window is a protocol error.
        err_d      = err_q | (IRAM_valid && (state_q != StCollect));
        advance    = 1'b0;

        unique case (state_q)
            StIdle, StFinish: begin
                if (start) begin
                    state_d    = StFetch;
                    crom_a_d   = 5'd0;
                    checksum_d = 14'd0;
                    wr_count_d = 7'd0;
                    err_d      = 1'b0;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                // Reserved codes are skipped without touching cmd, so they
                // can never appear on the command bus.
                if (CROM_Q >= FirstIllegal) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    cmd_d   = CROM_Q;
                    state_d = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (!busy) begin
                    state_d = StIssue;
                end else if (timeout_q == TimeoutMax) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end
            end
            StIssue: state_d = (cmd_q == 4'd0) ? StCollect : StGuard;
            // Controller may not have raised busy yet; wait one cycle blind.
            StGuard: advance = 1'b1;
            StCollect: begin
                if (capture) begin
                    checksum_d = checksum_q + {6'd0, IRAM_D};
                    if (wr_count_q != 7'd127) begin
                        wr_count_d = wr_count_q + 7'd1;
                    end
                end
                if (done) begin
                    state_d = StFinish;
                end else if (!capture && (timeout_q == TimeoutMax)) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end
            end
            default: state_d = StIdle;
        endcase

        // Move to the next ROM entry; running off the end without a
        // write-out command terminates the run instead of wrapping.
        if (advance) begin
            if (crom_a_q == 5'd31) begin
                err_d   = 1'b1;
                state_d = StFinish;
            end else begin
                crom_a_d = crom_a_q + 5'd1;
                state_d  = StFetch;
            end
        end
    end

    always_comb begin
        timeout_d = 10'd0;
        if ((state_d == state_q) && !capture &&
            ((state_q == StWaitRdy) || (state_q == StCollect))) begin
            timeout_d = timeout_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            crom_a_q   <= 5'd0;
            cmd_q      <= 4'd0;
            checksum_q <= 14'd0;
            wr_count_q <= 7'd0;
            err_q      <= 1'b0;
            timeout_q  <= 10'd0;
        end else begin
            state_q    <= state_d;
            crom_a_q   <= crom_a_d;
            cmd_q      <= cmd_d;
            checksum_q <= checksum_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    // Image memory keeps its contents across reset and across runs.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[IRAM_A] <= IRAM_D;
        end
    end

    assign rd_data   = mem[rd_addr];
    assign CROM_rd   = (state_q == StFetch);
    assign cmd_valid = (state_q == StIssue);
    assign host_done = (state_q == StFinish);
    assign CROM_A    = crom_a_q;
    assign cmd       = cmd_q;
    assign checksum  = checksum_q;
    assign wr_count  = wr_count_q;
    assign err       = err_q;

endmodule
